// File: rtl/serial_nibble_rx.sv
// Serial-to-parallel receiver for framed 4-bit words: start bit, 4 data bits
// LSB first, optional even parity, stop bit; oversampled at BIT_CYCLES/bit.
// Ports: CLK, CLR (sync reset), SIN (serial line, idles high);
//        DOUT (last good word), LOAD (1-cycle strobe when DOUT updates),
//        BUSY (frame in progress), FERR/PERR (sticky errors), OE = FERR|PERR.
module serial_nibble_rx #(
    parameter int BIT_CYCLES = 4,
    parameter bit PARITY_EN  = 1'b0
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       SIN,
    output logic [3:0] DOUT,
    output logic       LOAD,
    output logic       BUSY,
    output logic       FERR,
    output logic       PERR,
    output logic       OE
);

    localparam int CW   = $clog2(BIT_CYCLES);
    localparam int HALF = BIT_CYCLES / 2;

    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    shreg_q, shreg_d;
    logic          pend_q, pend_d;
    logic [3:0]    dout_q, dout_d;
    logic          load_q, load_d;
    logic          busy_q, busy_d;
    logic          ferr_q, ferr_d;
    logic          perr_q, perr_d;
    logic          oe_q, oe_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        pend_d  = pend_q;
        dout_d  = dout_q;
        load_d  = 1'b0;
        ferr_d  = ferr_q;
        perr_d  = perr_q;

        unique case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                pend_d = 1'b0;
                if (!SIN) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                // Mid-start-bit sample rejects glitches shorter than HALF.
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    idx_d   = 2'd0;
                    state_d = SIN ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = SIN;
                    idx_d          = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = PARITY_EN ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d   = '0;
                    // Odd total count of ones across data and parity bit.
                    pend_d  = SIN ^ (^shreg_q);
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d = '0;
                    if (SIN) begin
                        state_d = S_IDLE;
                        if (!pend_q) begin
                            dout_d = shreg_q;
                            load_d = 1'b1;
                            ferr_d = 1'b0;
                            perr_d = 1'b0;
                        end else begin
                            perr_d = 1'b1;
                        end
                    end else begin
                        state_d = S_WAIT;
                        ferr_d  = 1'b1;
                        if (pend_q) begin
                            perr_d = 1'b1;
                        end
                    end
                end
            end
            S_WAIT: begin
                // Line must return high before a new start can be seen.
                cnt_d = '0;
                if (SIN) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        oe_d   = ferr_d | perr_d;
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            shreg_q <= 4'd0;
            pend_q  <= 1'b0;
            dout_q  <= 4'd0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            pend_q  <= pend_d;
            dout_q  <= dout_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
            oe_q    <= oe_d;
        end
    end

    assign DOUT = dout_q;
    assign LOAD = load_q;
    assign BUSY = busy_q;
    assign FERR = ferr_q;
    assign PERR = perr_q;
    assign OE   = oe_q;

endmodule

// File: tb/tb_serial_nibble_rx.sv
// Bench for serial_nibble_rx: two instances (no parity / even parity) share
// one serial line and are compared every cycle against a timing-based model.
module tb_serial_nibble_rx;

    localparam int BC   = 4;
    localparam int HALF = BC / 2;

    logic       CLK = 1'b0;
    logic       CLR = 1'b1;
    logic       SIN = 1'b0;
    logic [3:0] dout [2];
    logic       load [2];
    logic       busy [2];
    logic       ferr [2];
    logic       perr [2];
    logic       oe   [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    serial_nibble_rx #(.BIT_CYCLES(BC), .PARITY_EN(1'b0)) u_np (
        .CLK(CLK), .CLR(CLR), .SIN(SIN),
        .DOUT(dout[0]), .LOAD(load[0]), .BUSY(busy[0]),
        .FERR(ferr[0]), .PERR(perr[0]), .OE(oe[0])
    );

    serial_nibble_rx #(.BIT_CYCLES(BC), .PARITY_EN(1'b1)) u_pe (
        .CLK(CLK), .CLR(CLR), .SIN(SIN),
        .DOUT(dout[1]), .LOAD(load[1]), .BUSY(busy[1]),
        .FERR(ferr[1]), .PERR(perr[1]), .OE(oe[1])
    );

    always #5 CLK = ~CLK;

    // Model: mode 0 = idle line watch, 1 = in frame, 2 = waiting for high.
    // Inside a frame everything is located by the edge offset from e0.
    int         m_mode [2];
    int         m_e0   [2];
    logic [3:0] m_data [2];
    bit         m_pp   [2];
    logic [3:0] e_dout [2];
    bit         e_load [2];
    bit         e_ferr [2];
    bit         e_perr [2];
    bit         e_busy [2];

    task automatic model_step(input int j, input int n);
        int k;
        int slot;
        e_load[j] = 1'b0;
        if (CLR) begin
            m_mode[j] = 0;
            e_dout[j] = 4'd0;
            e_ferr[j] = 1'b0;
            e_perr[j] = 1'b0;
        end else if (m_mode[j] == 0) begin
            if (!SIN) begin
                m_mode[j] = 1;
                m_e0[j]   = n;
                m_pp[j]   = 1'b0;
            end
        end else if (m_mode[j] == 2) begin
            if (SIN) m_mode[j] = 0;
        end else begin
            k = n - m_e0[j];
            if (k == HALF) begin
                if (SIN) m_mode[j] = 0;
            end else if (k > HALF && (k - HALF) % BC == 0) begin
                slot = (k - HALF) / BC;
                if (slot <= 4) begin
                    m_data[j][slot-1] = SIN;
                end else if (j == 1 && slot == 5) begin
                    m_pp[j] = SIN ^ (^m_data[j]);
                end else if (SIN) begin
                    m_mode[j] = 0;
                    if (!m_pp[j]) begin
                        e_dout[j] = m_data[j];
                        e_load[j] = 1'b1;
                        e_ferr[j] = 1'b0;
                        e_perr[j] = 1'b0;
                    end else begin
                        e_perr[j] = 1'b1;
                    end
                end else begin
                    m_mode[j] = 2;
                    e_ferr[j] = 1'b1;
                    if (m_pp[j]) e_perr[j] = 1'b1;
                end
            end
        end
        e_busy[j] = (m_mode[j] != 0);
    endtask

    always @(posedge CLK) begin
        cyc = cyc + 1;
        for (int j = 0; j < 2; j++) model_step(j, cyc);
    end

    task automatic chk(input string nm, input int j,
                       input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s[%0d] cyc=%0d got %0h expected %0h",
                     nm, j, cyc, act, exp);
        end
    endtask

    int load_cnt  [2] = '{0, 0};
    int last_load [2] = '{0, 0};

    always @(negedge CLK) begin
        if (cyc > 0) begin
            for (int j = 0; j < 2; j++) begin
                chk("dout", j, 32'(dout[j]), 32'(e_dout[j]));
                chk("load", j, 32'(load[j]), 32'(e_load[j]));
                chk("busy", j, 32'(busy[j]), 32'(e_busy[j]));
                chk("ferr", j, 32'(ferr[j]), 32'(e_ferr[j]));
                chk("perr", j, 32'(perr[j]), 32'(e_perr[j]));
                chk("oe", j, 32'(oe[j]), 32'(e_ferr[j] | e_perr[j]));
                if (load[j] === 1'b1) begin
                    load_cnt[j]  = load_cnt[j] + 1;
                    last_load[j] = cyc;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            SIN = 1'b1;
            CLR = 1'b0;
        end
    endtask

    task automatic low(input int n);
        repeat (n) begin
            @(negedge CLK);
            SIN = 1'b0;
        end
    endtask

    // Drives one frame; clr_at >= 0 pulses CLR at that cycle and aborts.
    task automatic frame(input logic [3:0] d, input bit usep, input bit p,
                         input bit stop, input int clr_at, output int e0);
        logic [6:0] v;
        int nb;
        if (usep) begin
            v  = {stop, p, d, 1'b0};
            nb = 7;
        end else begin
            v  = {1'b1, stop, d, 1'b0};
            nb = 6;
        end
        e0 = 0;
        for (int t = 0; t < nb * BC; t++) begin
            @(negedge CLK);
            if (t == 0) e0 = cyc + 1;
            SIN = v[t / BC];
            if (t == clr_at) begin
                CLR = 1'b1;
                @(negedge CLK);
                CLR = 1'b0;
                SIN = 1'b1;
                return;
            end
        end
    endtask

    task automatic all_reset_vals(input string nm);
        for (int j = 0; j < 2; j++) begin
            chk({nm, "_dout"}, j, 32'(dout[j]), 32'h0);
            chk({nm, "_load"}, j, 32'(load[j]), 32'h0);
            chk({nm, "_ferr"}, j, 32'(ferr[j]), 32'h0);
            chk({nm, "_perr"}, j, 32'(perr[j]), 32'h0);
            chk({nm, "_oe"}, j, 32'(oe[j]), 32'h0);
            chk({nm, "_busy"}, j, 32'(busy[j]), 32'h0);
        end
    endtask

    initial begin
        int e0;
        int c0;
        int c1;
        logic [3:0] rd;
        bit up;
        bit pb;
        bit sb;

        CLR = 1'b1;
        SIN = 1'b0;
        repeat (2) @(negedge CLK);
        CLR = 1'b0;
        SIN = 1'b1;
        all_reset_vals("reset");
        idle(2);
        chk("reset_nostart", 0, 32'(busy[0]), 32'h0);

        c0 = load_cnt[0];
        frame(4'b1011, 1'b0, 1'b0, 1'b1, -1, e0);
        idle(4);
        chk("good_dout", 0, 32'(dout[0]), 32'hb);
        chk("good_ltime", 0, 32'(last_load[0]), 32'(e0 + 22));
        chk("good_lcnt", 0, 32'(load_cnt[0] - c0), 32'd1);
        chk("good_oe", 0, 32'(oe[0]), 32'h0);

        c0 = load_cnt[0];
        low(1);
        idle(6);
        chk("false_busy", 0, 32'(busy[0]), 32'h0);
        chk("false_lcnt", 0, 32'(load_cnt[0] - c0), 32'd0);
        chk("false_dout", 0, 32'(dout[0]), 32'hb);
        chk("false_ferr", 0, 32'(ferr[0]), 32'h0);

        frame(4'b0110, 1'b0, 1'b0, 1'b0, -1, e0);
        low(5);
        chk("ferr_flag", 0, 32'(ferr[0]), 32'h1);
        chk("ferr_oe", 0, 32'(oe[0]), 32'h1);
        chk("ferr_busy", 0, 32'(busy[0]), 32'h1);
        chk("ferr_dout", 0, 32'(dout[0]), 32'hb);
        idle(3);
        chk("ferr_exit", 0, 32'(busy[0]), 32'h0);
        frame(4'b0011, 1'b0, 1'b0, 1'b1, -1, e0);
        idle(4);
        chk("rec_dout", 0, 32'(dout[0]), 32'h3);
        chk("rec_ferr", 0, 32'(ferr[0]), 32'h0);
        chk("rec_oe", 0, 32'(oe[0]), 32'h0);

        c1 = load_cnt[1];
        frame(4'b0111, 1'b1, 1'b1, 1'b1, -1, e0);
        idle(4);
        chk("par_ok_dout", 1, 32'(dout[1]), 32'h7);
        chk("par_ok_lcnt", 1, 32'(load_cnt[1] - c1), 32'd1);
        chk("par_ok_ltime", 1, 32'(last_load[1]), 32'(e0 + 26));
        c1 = load_cnt[1];
        frame(4'b0111, 1'b1, 1'b0, 1'b1, -1, e0);
        idle(4);
        chk("par_bad_perr", 1, 32'(perr[1]), 32'h1);
        chk("par_bad_oe", 1, 32'(oe[1]), 32'h1);
        chk("par_bad_lcnt", 1, 32'(load_cnt[1] - c1), 32'd0);

        frame(4'b1001, 1'b0, 1'b0, 1'b1, 3 * BC + 1, e0);
        all_reset_vals("clr_mid");
        idle(2);
        frame(4'b1001, 1'b0, 1'b0, 1'b1, -1, e0);
        idle(4);
        chk("after_clr_dout", 0, 32'(dout[0]), 32'h9);

        c0 = load_cnt[0];
        frame(4'b1010, 1'b0, 1'b0, 1'b1, -1, e0);
        frame(4'b0101, 1'b0, 1'b0, 1'b1, -1, e0);
        idle(4);
        chk("b2b_lcnt", 0, 32'(load_cnt[0] - c0), 32'd2);
        chk("b2b_dout", 0, 32'(dout[0]), 32'h5);

        for (int i = 0; i < 300; i++) begin
            rd = 4'($urandom);
            up = 1'($urandom);
            pb = (^rd) ^ ($urandom_range(0, 5) == 0);
            sb = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) == 0) begin
                low($urandom_range(1, HALF - 1));
                idle($urandom_range(1, 3));
            end
            if ($urandom_range(0, 14) == 0)
                frame(rd, up, pb, sb, $urandom_range(0, 5 * BC), e0);
            else
                frame(rd, up, pb, sb, -1, e0);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 4));
        end
        idle(40);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
